// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed BCD display driver: accepts a 14-bit binary value,
// converts it with a sequential double-dabble, and scans the result digit by digit.
module bcd_display_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_value,
    output logic        ovf,
    output logic [3:0]  digit_out,
    output logic [3:0]  digit_sel
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  CONV     = 1'b1;
    localparam logic [13:0] MAX_VAL  = 14'd9999;
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'd13;

    logic [0:0]  state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;

    logic [15:0] bcd_adj;
    logic [29:0] dabble;
    logic [3:0]  blank;

    // Add-3 correction on every BCD group ahead of the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign dabble = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONV;
                    bin_d   = (in_value > MAX_VAL) ? MAX_VAL : in_value;
                    ovf_d   = (in_value > MAX_VAL);
                    bcd_d   = 16'h0000;
                    cnt_d   = 4'd0;
                end
            end
            CONV: begin
                bin_d = dabble[13:0];
                bcd_d = dabble[29:14];
                cnt_d = cnt_q + 4'd1;
                // The last shift result goes straight to the display on the same edge.
                if (cnt_q == LAST_BIT) begin
                    disp_d  = dabble[29:14];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == DIV_LAST) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            cnt_q   <= 4'd0;
            disp_q  <= 16'd0;
            ovf_q   <= 1'b0;
            presc_q <= 16'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // A digit is blank when it and every more significant digit are zero.
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = BLANK_LZ && (disp_q[15:gi*4] == '0);
        end
    endgenerate

    assign in_ready  = (state_q == IDLE);
    assign ovf       = ovf_q;
    assign digit_sel = 4'b0001 << idx_q;
    assign digit_out = blank[idx_q] ? 4'hF : disp_q[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: two scanners (blanking on/off) share stimulus; a scoreboard
// holds the expected display for each accepted value until its conversion completes.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [13:0] in_value = 14'd0;
    logic        rdy_lz, rdy_nz, ovf_lz, ovf_nz;
    logic [3:0]  dout_lz, dout_nz, sel_lz, sel_nz;

    always #5 clk = ~clk;

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_lz),
        .in_value(in_value), .ovf(ovf_lz), .digit_out(dout_lz), .digit_sel(sel_lz)
    );
    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_nz),
        .in_value(in_value), .ovf(ovf_nz), .digit_out(dout_nz), .digit_sel(sel_nz)
    );

    typedef struct {
        int          value;
        logic        ovf;
        logic [15:0] lz;
        logic [15:0] nz;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   seen8   = 1'b0;

    always @(negedge clk) if (dout_lz == 4'd8 || dout_nz == 4'd8) seen8 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input int v);
        vec_t r;
        int   s, p;
        s = (v > 9999) ? 9999 : v;
        p = 1;
        r.value = v;
        r.ovf   = (v > 9999);
        for (int i = 0; i < 4; i++) begin
            r.nz[i*4 +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        r.lz = r.nz;
        if (r.nz[15:12] == 4'h0) r.lz[15:12] = 4'hF;
        if (r.nz[15:8] == 8'h00) r.lz[11:8] = 4'hF;
        if (r.nz[15:4] == 12'h000) r.lz[7:4] = 4'hF;
        return r;
    endfunction

    // Waits for IDLE, transfers one value; optionally leaves in_valid high with hold_val.
    task automatic send(input vec_t e, input bit hold, input int hold_val);
        int guard = 0;
        while (!rdy_lz && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready_timeout", {31'd0, rdy_lz}, 32'd1);
        in_valid = 1'b1;
        in_value = 14'(e.value);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (hold) in_value = 14'(hold_val);
        else in_valid = 1'b0;
        $display("[TB] sent %0d expect ovf=%0d lz=%h nz=%h", e.value, e.ovf, e.lz, e.nz);
    endtask

    // Checks 14-edge busy window after a transfer, then pops the scoreboard.
    task automatic convert_check(output vec_t e);
        bit bad = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (rdy_lz !== (k == 14) || rdy_nz !== (k == 14)) bad = 1'b1;
        end
        chk("busy_window", {31'd0, bad}, 32'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            e = model(0);
        end else begin
            e = sb_q.pop_front();
            chk("ovf_lz", {31'd0, ovf_lz}, {31'd0, e.ovf});
            chk("ovf_nz", {31'd0, ovf_nz}, {31'd0, e.ovf});
        end
    endtask

    task automatic check_scan(input vec_t e);
        for (int d = 0; d < 4; d++) begin
            int guard = 0;
            while (sel_lz !== (4'b0001 << d) && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            chk("scan_timeout", {28'd0, sel_lz}, {28'd0, 4'b0001 << d});
            chk("sel_match", {28'd0, sel_nz}, {28'd0, sel_lz});
            chk($sformatf("lz_digit%0d_%0d", d, e.value), {28'd0, dout_lz}, {28'd0, e.lz[d*4 +: 4]});
            chk($sformatf("nz_digit%0d_%0d", d, e.value), {28'd0, dout_nz}, {28'd0, e.nz[d*4 +: 4]});
        end
        $display("[TB] scanned %0d lz=%h nz=%h", e.value, e.lz, e.nz);
    endtask

    task automatic check_current(input vec_t e);
        for (int d = 0; d < 4; d++) begin
            if (sel_lz[d]) begin
                chk("current_lz", {28'd0, dout_lz}, {28'd0, e.lz[d*4 +: 4]});
                chk("current_nz", {28'd0, dout_nz}, {28'd0, e.nz[d*4 +: 4]});
            end
        end
    endtask

    task automatic wait_sel_change(output int cnt);
        logic [3:0] prev = sel_lz;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (sel_lz == prev && cnt < 20);
    endtask

    initial begin
        vec_t e, e2;
        int   cnt;
        logic [3:0] p;

        vecs[0] = '{1234,  1'b0, 16'h1234, 16'h1234};
        vecs[1] = '{7,     1'b0, 16'hFFF7, 16'h0007};
        vecs[2] = '{0,     1'b0, 16'hFFF0, 16'h0000};
        vecs[3] = '{1005,  1'b0, 16'h1005, 16'h1005};
        vecs[4] = '{12000, 1'b1, 16'h9999, 16'h9999};
        vecs[5] = '{5,     1'b0, 16'hFFF5, 16'h0005};
        vecs[6] = '{9999,  1'b0, 16'h9999, 16'h9999};
        vecs[7] = '{10000, 1'b1, 16'h9999, 16'h9999};
        vecs[8] = '{16383, 1'b1, 16'h9999, 16'h9999};
        vecs[9] = '{10,    1'b0, 16'hFF10, 16'h0010};

        // Asynchronous reset state, sampled before any clock edge.
        #2;
        chk("rst_sel", {28'd0, sel_lz}, 32'h1);
        chk("rst_dout", {28'd0, dout_lz}, 32'h0);
        chk("rst_ready", {31'd0, rdy_lz}, 32'h1);
        chk("rst_ovf", {31'd0, ovf_lz}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Scan period: each digit held 4 clocks, select rotates left.
        wait_sel_change(cnt);
        for (int t = 0; t < 4; t++) begin
            p = sel_lz;
            wait_sel_change(cnt);
            chk("scan_period", cnt, 32'd4);
            chk("scan_next", {28'd0, sel_lz}, {28'd0, {p[2:0], p[3]}});
        end

        for (int i = 0; i < 10; i++) begin
            send(vecs[i], 1'b0, 0);
            convert_check(e);
            check_scan(e);
        end

        // Back-pressure: 42 offered throughout the 300 conversion.
        send(model(300), 1'b1, 42);
        sb_q.push_back(model(42));
        convert_check(e);
        check_current(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_captured", {31'd0, rdy_lz}, 32'd0);
        check_current(e);
        convert_check(e2);
        chk("bp_value", e2.value, 32'd42);
        check_scan(e2);

        // Reset in the middle of converting 8888.
        send(model(8888), 1'b0, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, rdy_lz}, 32'd1);
        chk("mid_rst_sel", {28'd0, sel_lz}, 32'h1);
        chk("mid_rst_dout", {28'd0, dout_lz}, 32'h0);
        chk("mid_rst_ovf", {31'd0, ovf_lz}, 32'h0);
        void'(sb_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_scan(model(0));
        chk("post_rst_idle", {31'd0, rdy_lz}, 32'd1);

        // First transfer on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_value = 14'd5;
        sb_q.push_back(model(5));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_edge_xfer", {31'd0, rdy_lz}, 32'd0);
        convert_check(e);
        check_scan(e);

        chk("no_8888", {31'd0, seen8}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clocks each digit stays selected (legal range 2..65535).
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning 1 enables leading-zero blanking and 0 shows all four digits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_value is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a value this cycle.
REQ-007 SHALL have port in_value, input, 14 bits: unsigned binary number to display.
REQ-008 SHALL have port ovf, output, 1 bit: the last accepted value exceeded 9999.
REQ-009 SHALL have port digit_out, output, 4 bits: BCD code of the selected digit, or 4'hF for blank; it drives the downstream binary-to-7-segment decoder, which shows codes 10-15 as blank.
REQ-010 SHALL have port digit_sel, output, 4 bits: one-hot, active-high digit enable; bit 0 is the least significant digit.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and CONV; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-012 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; in_valid in CONV SHALL be ignored and nothing is captured.
REQ-013 On a transfer the block SHALL capture min(in_value, 9999), set ovf to (in_value > 9999), and enter CONV.
REQ-014 CONV SHALL run a sequential shift-and-add-3 (double-dabble) conversion of the captured 14-bit value.
REQ-015 The conversion SHALL take exactly 14 clocks: one shift per clock, with each 4-bit BCD group >= 5 getting +3 before the shift.
REQ-016 Timing: transfer at edge N; the four-digit display register SHALL load all digits at edge N+14; the FSM SHALL return to IDLE at edge N+14; in_ready SHALL be 1 from that edge onward.
REQ-017 The display register SHALL hold its previous contents throughout CONV, so no partial result ever appears on digit_out.
REQ-018 ovf SHALL change only on a transfer.
REQ-019 A 16-bit prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-020 On the prescaler's wrap edge, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-021 digit_sel SHALL be 1 << index.
REQ-022 digit_out SHALL be display digit[index], or 4'hF when that digit is blanked.
REQ-023 digit_out and digit_sel SHALL be combinational from registered state only, with no path from in_value or in_valid.
REQ-024 With BLANK_LZ=1, digit i (i = 1..3) SHALL be blanked when digits i through 3 are all zero; digit 0 SHALL never be blanked.
REQ-025 With BLANK_LZ=0, no digit SHALL be blanked.
REQ-026 A display-register load SHALL take effect on digit_out in the same cycle it is visible, without disturbing the prescaler or the index.
REQ-027 Scanning SHALL run continuously, independent of the FSM state.

Reset
REQ-028 While rst is 1, and asynchronously on its assertion, the block SHALL set: state IDLE (in_ready=1), display digits all 0, captured value and conversion registers 0, ovf 0, prescaler 0, index 0 (digit_sel=4'b0001, digit_out=4'h0).
REQ-029 Reset asserted during CONV SHALL abandon the conversion; the display SHALL NOT update from it.
REQ-030 After rst deasserts, the first transfer SHALL be possible on the first rising edge.

Verification
REQ-031 Reset check: assert rst -> digit_sel=0001, digit_out=0, in_ready=1, ovf=0.
REQ-032 Conversion and scan (SCAN_DIV=4): send 1234 at edge N -> in_ready=0 for edges N+1..N+13, 1 at N+14; scan then shows (0001,4),(0010,3),(0100,2),(1000,1), 4 clocks each.
REQ-033 Leading-zero blanking (BLANK_LZ=1): send 7 -> digits 0..3 show 7,F,F,F; send 0 -> 0,F,F,F; send 1005 -> 5,0,0,1. Same sequence with BLANK_LZ=0: 0007, 0000, 1005.
REQ-034 Saturation: send 12000 -> ovf=1, display 9999; then send 5 -> ovf=0, display 5,F,F,F.
REQ-035 Back-pressure: hold in_valid=1 with 42 during CONV of 300 -> 42 not captured in CONV; 42 captured on the first IDLE edge; display shows 300 and then 42.
REQ-036 Reset mid-operation: assert rst at edge N+7 of a conversion of 8888 -> display 0000 (shown 0,F,F,F), in_ready=1, no 8888 ever appears.
